// File: rtl/spi_slave_sync.sv
// SPI slave oversampled into the clk domain: configurable word width and CPOL/CPHA,
// valid/ready RX word output, one-deep TX holding register, overrun/underrun pulses.
module spi_slave_sync #(
    parameter int                DATA_W      = 8,
    parameter bit                CPOL        = 1'b0,
    parameter bit                CPHA        = 1'b0,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_IDLE     = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int              CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, mosi_sr;
    logic                   sclk_q, cs_q;
    logic                   sclk_sync, cs_sync, mosi_sync;

    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      rx_shift, rx_next;
    logic [DATA_W-1:0]      tx_shift, tx_hold;
    logic                   tx_full;

    logic sclk_act, sclk_act_q;
    logic lead, trail, cs_fall, cs_rise;
    logic sample_edge, shift_edge, do_load, bypass, tx_wr;

    assign sclk_sync = sclk_sr[SYNC_STAGES-1];
    assign cs_sync   = cs_sr[SYNC_STAGES-1];
    assign mosi_sync = mosi_sr[SYNC_STAGES-1];

    // "Active" means sclk is away from its idle level, which makes the edge logic CPOL-agnostic.
    assign sclk_act   = sclk_sync ^ CPOL;
    assign sclk_act_q = sclk_q ^ CPOL;
    assign lead       = sclk_act & ~sclk_act_q & ~cs_sync;
    assign trail      = ~sclk_act & sclk_act_q & ~cs_sync;
    assign cs_fall    = cs_q & ~cs_sync;
    assign cs_rise    = ~cs_q & cs_sync;

    assign sample_edge = CPHA ? trail : lead;
    assign shift_edge  = CPHA ? lead : trail;
    assign do_load     = (cs_fall && !CPHA) || (shift_edge && (bit_cnt == '0));
    assign bypass      = do_load && !tx_full && tx_valid;
    assign tx_wr       = tx_valid && tx_ready && !bypass;
    assign rx_next     = {rx_shift[DATA_W-2:0], mosi_sync};

    assign tx_ready    = ~tx_full;
    assign busy        = ~cs_sync;
    assign spi_miso_oe = ~cs_sync;
    assign spi_miso    = tx_shift[DATA_W-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sr <= {SYNC_STAGES{CPOL}};
            cs_sr   <= '1;
            mosi_sr <= '0;
            sclk_q  <= CPOL;
            cs_q    <= 1'b1;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], spi_sclk};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
            sclk_q  <= sclk_sync;
            cs_q    <= cs_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_shift    <= TX_IDLE;
            tx_hold     <= '0;
            tx_full     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;

            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            // A CS edge in either direction restarts the word; partial RX bits are dropped.
            if (cs_fall || cs_rise) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end

            if (sample_edge) begin
                rx_shift <= rx_next;
                if (bit_cnt == LAST) begin
                    bit_cnt    <= '0;
                    rx_data    <= rx_next;
                    rx_valid   <= 1'b1;
                    rx_overrun <= rx_valid && !rx_ready;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (do_load) begin
                if (tx_full) begin
                    tx_shift <= tx_hold;
                    tx_full  <= 1'b0;
                end else if (tx_valid) begin
                    tx_shift <= tx_data;
                end else begin
                    tx_shift    <= TX_IDLE;
                    tx_underrun <= 1'b1;
                end
            end else if (shift_edge) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end

            if (tx_wr) begin
                tx_hold <= tx_data;
                tx_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: a mode-0 byte instance and a mode-3 16-bit instance,
// driven by a bit-level SPI master, with an RX scoreboard checked by a monitor.
module tb_spi_slave_sync;

    localparam int H = 8;  // SCLK half period in clk cycles

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // mode 0, 8-bit
    logic       sclk1, cs1, mosi1, miso1, oe1, rx_valid1, rx_ready1, ovr1;
    logic       tx_valid1, tx_ready1, und1, busy1;
    logic [7:0] rx_data1, tx_data1;
    // mode 3, 16-bit
    logic        sclk2, cs2, mosi2, miso2, oe2, rx_valid2, rx_ready2, ovr2;
    logic        tx_valid2, tx_ready2, und2, busy2;
    logic [15:0] rx_data2, tx_data2;

    spi_slave_sync u_dut1 (
        .clk(clk), .rst_n(rst_n), .spi_sclk(sclk1), .spi_cs_n(cs1), .spi_mosi(mosi1),
        .spi_miso(miso1), .spi_miso_oe(oe1), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .rx_ready(rx_ready1), .rx_overrun(ovr1), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .tx_underrun(und1), .busy(busy1)
    );

    spi_slave_sync #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .spi_sclk(sclk2), .spi_cs_n(cs2), .spi_mosi(mosi2),
        .spi_miso(miso2), .spi_miso_oe(oe2), .rx_data(rx_data2), .rx_valid(rx_valid2),
        .rx_ready(rx_ready2), .rx_overrun(ovr2), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .tx_underrun(und2), .busy(busy2)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n_ovr1 = 0, n_und1 = 0, n_ovr2 = 0, n_und2 = 0;
    logic [7:0]  q1[$];
    logic [15:0] q2[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops the expected word on every RX handshake and counts flag pulses.
    always begin
        @(negedge clk);
        #2;
        if (rst_n === 1'b1) begin
            if (rx_valid1 && rx_ready1) begin
                if (q1.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rx1_unexpected: got %0h expected no word", rx_data1);
                end else chk("rx1_data", 32'(rx_data1), 32'(q1.pop_front()));
            end
            if (rx_valid2 && rx_ready2) begin
                if (q2.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rx2_unexpected: got %0h expected no word", rx_data2);
                end else chk("rx2_data", 32'(rx_data2), 32'(q2.pop_front()));
            end
            if (ovr1) n_ovr1++;
            if (und1) n_und1++;
            if (ovr2) n_ovr2++;
            if (und2) n_und2++;
        end
    end

    task automatic tx_write(input int sel, input logic [15:0] d);
        int t = 0;
        while (!(sel == 0 ? tx_ready1 : tx_ready2) && t < 200) begin
            wait_clk(1);
            t++;
        end
        if (t >= 200) begin
            n_chk++; n_fail++;
            $display("FAIL tx_ready_timeout: got 0 expected 1 within 200 cycles");
        end
        if (sel == 0) begin tx_data1 = d[7:0]; tx_valid1 = 1'b1; end
        else          begin tx_data2 = d;      tx_valid2 = 1'b1; end
        wait_clk(1);
        tx_valid1 = 1'b0;
        tx_valid2 = 1'b0;
    endtask

    task automatic cs_low(input int sel);
        if (sel == 0) cs1 = 1'b0; else cs2 = 1'b0;
        wait_clk(H);
    endtask

    task automatic cs_high(input int sel);
        if (sel == 0) cs1 = 1'b1; else cs2 = 1'b1;
        wait_clk(H);
    endtask

    // sel 0: mode 0 (sample on rising); sel 1: mode 3 (drive on falling, sample on rising).
    task automatic xfer(input int sel, input int nbits, input logic [15:0] mo,
                        output logic [15:0] mi);
        mi = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (sel == 0) begin
                mosi1 = mo[i];
                wait_clk(H);
                sclk1 = 1'b1;
                mi = {mi[14:0], miso1};
                wait_clk(H);
                sclk1 = 1'b0;
            end else begin
                sclk2 = 1'b0;
                mosi2 = mo[i];
                wait_clk(H);
                sclk2 = 1'b1;
                mi = {mi[14:0], miso2};
                wait_clk(H);
            end
        end
        wait_clk(H);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] mi;
        int o0, u0;
        rst_n = 1'b0;
        sclk1 = 1'b0; cs1 = 1'b1; mosi1 = 1'b0; rx_ready1 = 1'b1; tx_valid1 = 1'b0; tx_data1 = '0;
        sclk2 = 1'b1; cs2 = 1'b1; mosi2 = 1'b0; rx_ready2 = 1'b1; tx_valid2 = 1'b0; tx_data2 = '0;
        wait_clk(4);
        chk("rst_rx_data",  32'(rx_data1), 32'h0);
        chk("rst_rx_valid", 32'(rx_valid1), 32'h0);
        chk("rst_busy",     32'(busy1), 32'h0);
        chk("rst_oe",       32'(oe1), 32'h0);
        chk("rst_miso",     32'(miso1), 32'h1);
        chk("rst_tx_ready", 32'(tx_ready1), 32'h1);
        chk("rst_flags",    32'({ovr1, und1}), 32'h0);
        rst_n = 1'b1;
        wait_clk(4);

        // 1: single word, queued TX
        o0 = n_ovr1; u0 = n_und1;
        tx_write(0, 16'h00A5);
        chk("t1_tx_ready_full", 32'(tx_ready1), 32'h0);
        cs_low(0);
        chk("t1_busy", 32'(busy1), 32'h1);
        chk("t1_oe", 32'(oe1), 32'h1);
        chk("t1_tx_ready_free", 32'(tx_ready1), 32'h1);
        tx_write(0, 16'h005B);
        q1.push_back(8'h3C);
        xfer(0, 8, 16'h003C, mi);
        chk("t1_miso", 32'(mi), 32'h00A5);
        chk("t1_overrun", 32'(n_ovr1 - o0), 32'h0);
        chk("t1_underrun", 32'(n_und1 - u0), 32'h0);
        cs_high(0);
        chk("t1_oe_off", 32'(oe1), 32'h0);

        // 2: back-to-back words under one CS
        u0 = n_und1;
        tx_write(0, 16'h0011);
        cs_low(0);
        tx_write(0, 16'h0022);
        q1.push_back(8'h5A);
        xfer(0, 8, 16'h005A, mi);
        chk("t2_miso0", 32'(mi), 32'h0011);
        tx_write(0, 16'h0077);
        q1.push_back(8'hC3);
        xfer(0, 8, 16'h00C3, mi);
        chk("t2_miso1", 32'(mi), 32'h0022);
        chk("t2_underrun", 32'(n_und1 - u0), 32'h0);
        cs_high(0);

        // 3: nothing queued at CS fall
        u0 = n_und1;
        cs_low(0);
        tx_write(0, 16'h0055);
        q1.push_back(8'h00);
        xfer(0, 8, 16'h0000, mi);
        chk("t3_miso_idle", 32'(mi), 32'h00FF);
        chk("t3_underrun", 32'(n_und1 - u0), 32'h1);
        cs_high(0);

        // 4: consumer stalled across two words
        o0 = n_ovr1; u0 = n_und1;
        rx_ready1 = 1'b0;
        cs_low(0);
        xfer(0, 8, 16'h0001, mi);
        xfer(0, 8, 16'h0002, mi);
        chk("t4_rx_valid", 32'(rx_valid1), 32'h1);
        chk("t4_rx_data", 32'(rx_data1), 32'h02);
        chk("t4_overrun", 32'(n_ovr1 - o0), 32'h1);
        chk("t4_underrun", 32'(n_und1 - u0), 32'h3);
        cs_high(0);
        q1.push_back(8'h02);
        rx_ready1 = 1'b1;
        wait_clk(3);
        chk("t4_rx_cleared", 32'(rx_valid1), 32'h0);

        // 5: aborted partial word, then a full word
        u0 = n_und1;
        cs_low(0);
        xfer(0, 3, 16'h0005, mi);
        cs_high(0);
        chk("t5_no_partial", 32'(rx_valid1), 32'h0);
        chk("t5_busy_off", 32'(busy1), 32'h0);
        cs_low(0);
        q1.push_back(8'h96);
        xfer(0, 8, 16'h0096, mi);
        cs_high(0);
        chk("t5_underrun", 32'(n_und1 - u0), 32'h3);

        // 6: mode 3, 16-bit; then reset mid-word with CS held
        u0 = n_und2;
        tx_write(1, 16'h1234);
        cs_low(1);
        q2.push_back(16'hBEEF);
        xfer(1, 16, 16'hBEEF, mi);
        chk("t6_miso", 32'(mi), 32'h1234);
        chk("t6_underrun", 32'(n_und2 - u0), 32'h0);
        chk("t6_overrun", 32'(n_ovr2), 32'h0);
        cs_high(1);
        cs_low(1);
        xfer(1, 5, 16'h001F, mi);
        rst_n = 1'b0;
        wait_clk(1);
        chk("t6_rst_rx_data",  32'(rx_data2), 32'h0);
        chk("t6_rst_rx_valid", 32'(rx_valid2), 32'h0);
        chk("t6_rst_busy",     32'(busy2), 32'h0);
        chk("t6_rst_oe",       32'(oe2), 32'h0);
        chk("t6_rst_miso",     32'(miso2), 32'h1);
        chk("t6_rst_tx_ready", 32'(tx_ready2), 32'h1);
        chk("t6_rst_flags",    32'({ovr2, und2}), 32'h0);
        rst_n = 1'b1;
        wait_clk(5);
        chk("t6_cs_held_busy", 32'(busy2), 32'h1);
        chk("t6_cs_held_oe", 32'(oe2), 32'h1);
        cs_high(1);
        chk("t6_busy_off", 32'(busy2), 32'h0);

        wait_clk(4);
        chk("q1_drained", 32'(q1.size()), 32'h0);
        chk("q2_drained", 32'(q2.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
Parametrised SPI slave, fully synchronous to the system clock. SCLK, CS_N and MOSI are oversampled through synchronisers, and edges are detected in the clk domain, so there is no second clock domain. Word width and SPI mode (CPOL/CPHA) are configurable. Provides a valid/ready RX word output, a one-deep TX holding register with valid/ready, and overrun/underrun flags. It replaces the mode-0-only, dual-clock byte interface in front of the QOA decoder core.

Parameters:
DATA_W, 8, word width in bits (≥2); MSB first.
CPOL, 0, SCLK idle level.
CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
SYNC_STAGES, 2, synchroniser depth on SCLK/CS_N/MOSI (≥2).
TX_IDLE, {DATA_W{1'b1}}, word shifted out when no TX word is queued.

Ports:
clk  in  1  system clock, the only clock.
rst_n  in  1  reset, synchronous, active-low.
spi_sclk  in  1  SPI clock, asynchronous.
spi_cs_n  in  1  chip select, active low, asynchronous.
spi_mosi  in  1  master data in.
spi_miso  out  1  slave data out; equals tx_shift[DATA_W-1].
spi_miso_oe  out  1  output enable; equals ~cs_sync.
rx_data  out  DATA_W  last complete received word.
rx_valid  out  1  rx_data holds an unread word.
rx_ready  in  1  consumer accepts rx_data when rx_valid&&rx_ready.
rx_overrun  out  1  1-cycle pulse: a word completed while rx_valid=1 and rx_ready=0.
tx_data  in  DATA_W  word to send.
tx_valid  in  1  tx_data offered.
tx_ready  out  1  ~tx_full.
tx_underrun  out  1  1-cycle pulse: a load occurred with nothing queued.
busy  out  1  ~cs_sync (selected).

Behaviour:
- Reset: synchroniser flops reset to idle values (sclk=CPOL, cs_n=1, mosi=0). bit_cnt=0, rx_shift=0, tx_shift=TX_IDLE, tx_full=0. Outputs: rx_data=0, rx_valid=0, rx_overrun=0, tx_underrun=0, busy=0, spi_miso_oe=0, spi_miso=TX_IDLE[DATA_W-1].
- Edges are detected on the synchronised signals (last stage vs. a registered copy).
- Leading edge: sclk leaves CPOL. Trailing edge: sclk returns to CPOL. The sample edge and shift edge are selected by CPHA.
- Edges are ignored while cs_sync=1.
- Timing requirement: each SCLK level must last ≥ SYNC_STAGES+2 clk cycles.
- cs_n falling edge: bit_cnt←0. If CPHA=0, perform a load immediately (MSB valid before the first edge).
- Sample edge: rx_shift←{rx_shift[DATA_W-2:0], mosi_sync}; bit_cnt←bit_cnt+1.
  - If bit_cnt==DATA_W-1: bit_cnt wraps to 0, rx_data←{rx_shift[DATA_W-2:0], mosi_sync}, rx_valid←1 in the next cycle.
  - If rx_valid was already 1 and there is no handshake in the same cycle: the new word overwrites rx_data and rx_overrun pulses.
- Shift edge: if bit_cnt==0, perform a load; otherwise tx_shift shifts left by 1 (LSB filled with 0).
- Load:
  - If tx_full: tx_shift←tx_hold and tx_full←0.
  - Else if tx_valid in the same cycle: tx_shift←tx_data directly (bypass). tx_ready stays high; no underrun; tx_full stays 0.
  - Else: tx_shift←TX_IDLE and tx_underrun pulses.
- TX write: tx_valid&&tx_ready (outside a bypass) → tx_hold←tx_data, tx_full←1.
- rx_valid&&rx_ready clears rx_valid. If a new word completes in the same cycle, rx_valid stays 1 with the new data and there is no overrun.
- cs_n rising edge, mid-word: bit_cnt←0 and partial RX bits are discarded (rx_data/rx_valid unchanged). The partial TX word is lost; tx_hold is untouched. spi_miso_oe drops with cs_sync.
- Back-to-back words without releasing CS are supported indefinitely via bit_cnt wrap.
- Reset while CS is held low: after reset, cs_sync sees a falling edge after SYNC_STAGES+1 cycles and normal cs-fall handling applies.
- bit_cnt width: $clog2(DATA_W).

Test Plan:
1. Mode 0, DATA_W=8. Queue tx 0xA5, CS low, master sends 0x3C → rx_data=0x3C, rx_valid=1; MISO sampled by the master = 0xA5; no under/overrun.
2. Mode 0, two words back-to-back without releasing CS. tx 0x11 then 0x22 written as tx_ready allows; master sends 0x5A, 0xC3 → two rx_valid handshakes 0x5A, 0xC3; MISO 0x11, 0x22.
3. No TX queued, master sends 0x00 → MISO 0xFF (TX_IDLE), tx_underrun pulses once at the load.
4. rx_ready held 0, master sends 0x01 then 0x02 → rx_overrun pulses once, rx_data=0x02, rx_valid=1; raising rx_ready clears rx_valid.
5. CS released after 3 bits (101), then a full word 0x96 → single rx_valid with 0x96; the partial bits do not appear.
6. CPOL=1, CPHA=1, DATA_W=16. tx 0x1234, master sends 0xBEEF → rx_data=0xBEEF, MISO=0x1234; rst_n pulsed low mid-word → all outputs at reset values next cycle.
